// File: rtl/btn_event_decoder_pkg.sv
// Shared definitions for the button event decoder: state encodings and elaboration helpers.
package btn_event_decoder_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE    = 2'd0,
        BTN_PRESSED = 2'd1,
        BTN_HELD    = 2'd2
    } btn_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_event_decoder_if.sv
// Button level in, single-cycle game events out; one bundle per button.
interface btn_event_decoder_if;
    import btn_event_decoder_pkg::*;

    logic btnIn;
    logic repeatEnable;
    logic pressPulse;
    logic releasePulse;
    logic longPressPulse;
    logic repeatPulse;
    logic held;

    modport master (
        output btnIn,
        output repeatEnable,
        input  pressPulse,
        input  releasePulse,
        input  longPressPulse,
        input  repeatPulse,
        input  held
    );

    modport slave (
        input  btnIn,
        input  repeatEnable,
        output pressPulse,
        output releasePulse,
        output longPressPulse,
        output repeatPulse,
        output held
    );
endinterface

// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into press/release/long-press/repeat pulses plus a held level.
module btn_event_decoder
    import btn_event_decoder_pkg::*;
#(
    parameter int unsigned CLKIN_FREQ        = 27_000_000,
    parameter real         LONG_PRESS_PERIOD = 0.5,
    parameter real         REPEAT_PERIOD     = 0.1,
    parameter logic        IDLE_STATE        = 1'b1
) (
    input logic                clk,
    input logic                reset,
    btn_event_decoder_if.slave bus
);

    localparam int unsigned LONG_CYCLES   = int'(real'(CLKIN_FREQ) * LONG_PRESS_PERIOD);
    localparam int unsigned REPEAT_CYCLES = int'(real'(CLKIN_FREQ) * REPEAT_PERIOD);
    localparam int unsigned CNT_W         = $clog2(max_u(LONG_CYCLES, REPEAT_CYCLES));

    if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("btn_event_decoder: LONG_CYCLES and REPEAT_CYCLES must both be >= 2");
    end

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    btn_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             btn_prev;
    logic             press_q;
    logic             release_q;
    logic             long_q;
    logic             repeat_q;
    logic             held_q;

    logic press_edge;
    logic release_edge;

    assign press_edge   = (bus.btnIn != IDLE_STATE) && (btn_prev == IDLE_STATE);
    assign release_edge = (bus.btnIn == IDLE_STATE) && (btn_prev != IDLE_STATE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BTN_IDLE;
            cnt       <= '0;
            btn_prev  <= IDLE_STATE;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            btn_prev  <= bus.btnIn;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            case (state)
                BTN_IDLE: begin
                    if (press_edge) begin
                        state   <= BTN_PRESSED;
                        press_q <= 1'b1;
                        held_q  <= 1'b1;
                        cnt     <= '0;
                    end
                end
                BTN_PRESSED: begin
                    // Release takes priority over reaching the long-press count.
                    if (release_edge) begin
                        state     <= BTN_IDLE;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        cnt       <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state  <= BTN_HELD;
                        long_q <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BTN_HELD: begin
                    if (release_edge) begin
                        state     <= BTN_IDLE;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        cnt       <= '0;
                    end else if (cnt == REPEAT_LAST) begin
                        cnt      <= '0;
                        repeat_q <= bus.repeatEnable;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= BTN_IDLE;
                    held_q <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    assign bus.pressPulse     = press_q;
    assign bus.releasePulse   = release_q;
    assign bus.longPressPulse = long_q;
    assign bus.repeatPulse    = repeat_q;
    assign bus.held           = held_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Self-checking bench for btn_event_decoder: directed tap/hold vectors plus randomized traffic.
module tb_btn_event_decoder;

    localparam int  LONG = 10;
    localparam int  REP  = 4;
    localparam bit  IDLE = 1'b1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    btn_event_decoder_if bus ();

    btn_event_decoder #(
        .CLKIN_FREQ       (1000),
        .LONG_PRESS_PERIOD(0.01),
        .REPEAT_PERIOD    (0.004),
        .IDLE_STATE       (1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Output vector layout: {press, release, long, repeat, held}
    logic [4:0] got_v;
    logic [4:0] exp_v;
    logic [3:0] prev_pulses = '0;

    // Reference model: press-relative cycle index k, events from plain arithmetic on k.
    bit m_active = 1'b0;
    int m_k      = 0;
    bit m_prev   = IDLE;

    task automatic model_edge(input bit b, input bit rep, input bit rst);
        bit press_e;
        bit rel_e;
        exp_v = '0;
        if (rst) begin
            m_active = 1'b0;
            m_prev   = IDLE;
            return;
        end
        press_e = (b != IDLE) && (m_prev == IDLE);
        rel_e   = (b == IDLE) && (m_prev != IDLE);
        m_prev  = b;
        if (!m_active) begin
            if (press_e) begin
                m_active = 1'b1;
                m_k      = 0;
                exp_v[4] = 1'b1;
            end
        end else if (rel_e) begin
            m_active = 1'b0;
            exp_v[3] = 1'b1;
        end else begin
            m_k++;
            if (m_k == LONG) exp_v[2] = 1'b1;
            else if (m_k > LONG && ((m_k - LONG) % REP) == 0) exp_v[1] = rep;
        end
        exp_v[0] = m_active;
    endtask

    task automatic check_vec(input string name, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b (press,release,long,repeat,held) t=%0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic step(input bit b, input bit rep, input bit rst, input string tag);
        bus.btnIn        = b;
        bus.repeatEnable = rep;
        reset            = rst;
        @(posedge clk);
        model_edge(b, rep, rst);
        #1;
        got_v = {bus.pressPulse, bus.releasePulse, bus.longPressPulse, bus.repeatPulse, bus.held};
        check_vec(tag, got_v, exp_v);
        check_int({tag, "_onehot"}, ($countones(got_v[4:1]) <= 1) ? 1 : 0, 1);
        check_int({tag, "_width"}, ((got_v[4:1] & prev_pulses) == 4'b0) ? 1 : 0, 1);
        prev_pulses = got_v[4:1];
    endtask

    typedef struct {
        string name;
        int    low_len;
        bit    rep;
        int    press_t;
        int    long_t;
        int    rep_n;
        int    rep_first;
        int    rel_t;
        int    held_n;
    } vec_t;

    vec_t vecs[4];

    task automatic run_vec(input vec_t v);
        int press_t;
        int long_t;
        int rep_n;
        int rep_first;
        int rel_t;
        int held_n;
        press_t = 0; long_t = 0; rep_n = 0; rep_first = 0; rel_t = 0; held_n = 0;
        for (int i = 0; i < v.low_len + 6; i++) begin
            step((i < v.low_len) ? 1'b0 : 1'b1, v.rep, 1'b0, v.name);
            if (got_v[4]) press_t = i + 1;
            if (got_v[3]) rel_t = i + 1;
            if (got_v[2]) long_t = i + 1;
            if (got_v[1]) begin
                if (rep_n == 0) rep_first = i + 1;
                rep_n++;
            end
            if (got_v[0]) held_n++;
        end
        check_int({v.name, "_press_t"}, press_t, v.press_t);
        check_int({v.name, "_long_t"}, long_t, v.long_t);
        check_int({v.name, "_rep_n"}, rep_n, v.rep_n);
        check_int({v.name, "_rep_first"}, rep_first, v.rep_first);
        check_int({v.name, "_release_t"}, rel_t, v.rel_t);
        check_int({v.name, "_held_n"}, held_n, v.held_n);
    endtask

    initial begin
        // Cycle offsets relative to the first edge that samples the button low (0 = none).
        vecs[0] = '{"short_tap",   5, 1'b1, 1,  0, 0,  0,  6,  5};
        vecs[1] = '{"long_rep_on", 30, 1'b1, 1, 11, 4, 15, 31, 30};
        vecs[2] = '{"long_rep_off", 30, 1'b0, 1, 11, 0,  0, 31, 30};
        vecs[3] = '{"rel_at_term", 10, 1'b1, 1,  0, 0,  0, 11, 10};

        bus.btnIn        = IDLE;
        bus.repeatEnable = 1'b0;
        reset            = 1'b1;
        step(IDLE, 1'b0, 1'b1, "reset");
        step(IDLE, 1'b0, 1'b1, "reset");
        check_vec("reset_state", got_v, 5'b0);
        for (int i = 0; i < 3; i++) step(IDLE, 1'b0, 1'b0, "idle");

        for (int v = 0; v < 4; v++) run_vec(vecs[v]);

        // Reset while in HELD, button kept low across and after reset.
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, "pre_rst_hold");
        step(1'b0, 1'b1, 1'b1, "rst_mid_hold");
        check_vec("rst_mid_hold_zero", got_v, 5'b0);
        step(1'b0, 1'b1, 1'b0, "post_rst");
        check_vec("post_rst_press", got_v, 5'b10001);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, "post_rst_hold");
        for (int i = 0; i < 4; i++) step(IDLE, 1'b1, 1'b0, "post_rst_rel");

        // Random press/release traffic with occasional mid-press reset.
        for (int n = 0; n < 1000; n++) begin
            int  plen;
            int  rlen;
            int  rst_at;
            bit  rep;
            plen   = int'($urandom_range(1, 40));
            rlen   = int'($urandom_range(1, 40));
            rep    = 1'($urandom_range(0, 1));
            rst_at = ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 39)) : -1;
            for (int i = 0; i < plen; i++) step(1'b0, rep, (i == rst_at) ? 1'b1 : 1'b0, "rand_press");
            for (int i = 0; i < rlen; i++) step(IDLE, rep, 1'b0, "rand_release");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
